// File: rtl/fifo_dual_read_drain.sv
// fifo_dual_read_drain: drains PAIR_COUNT words from each read port of the
// dual-read FIFO and merges them into one valid/ready stream of word pairs.
// Each lane has a 2-entry skid buffer that absorbs the 1-cycle read latency,
// the port-A write-priority stall and skew between the two lanes.
// Optional feature macro: FIFO_DRAIN_OUT_REG_EN (registered output stage).
module fifo_dual_read_drain #(
  parameter int DATA_WIDTH = 128,
  parameter int PAIR_COUNT = 2560
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data_a,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data_b,
  input  logic                    fifo_empty_a,
  input  logic                    fifo_empty_b,
  input  logic                    fifo_wr_en,
  output logic                    fifo_rd_en_a,
  output logic                    fifo_rd_en_b,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CW = $clog2(PAIR_COUNT + 1);
  localparam logic [CW-1:0] PC_C   = CW'(PAIR_COUNT);
  localparam logic [CW-1:0] LAST_C = CW'(PAIR_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   popped_reg;

  // Per-lane views so both lanes share one generate body (index 0 = A, 1 = B).
  logic [1:0]            lane_empty;
  logic [1:0]            lane_block;
  logic [1:0]            lane_rd_en;
  logic [1:0]            lane_head_valid;
  logic [1:0]            lane_issued_full;
  logic [DATA_WIDTH-1:0] lane_rd_data [2];
  logic [DATA_WIDTH-1:0] lane_head    [2];

  logic run;
  logic frame_clear;
  logic pop;
  logic accept;
  logic last_accept;

  assign run          = (state_reg == S_RUN);
  assign frame_clear  = (state_reg == S_IDLE) & start;
  assign accept       = out_valid & out_ready;
  assign last_accept  = accept & (popped_reg == LAST_C);

  // A FIFO write steals port A for that cycle; port B is never blocked.
  assign lane_empty      = {fifo_empty_b, fifo_empty_a};
  assign lane_block      = {1'b0, fifo_wr_en};
  assign lane_rd_data[0] = fifo_rd_data_a;
  assign lane_rd_data[1] = fifo_rd_data_b;
  assign fifo_rd_en_a    = lane_rd_en[0];
  assign fifo_rd_en_b    = lane_rd_en[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] mem_reg [2];
      logic                  wr_ptr_reg;
      logic                  rd_ptr_reg;
      logic [1:0]            occ_reg;
      logic                  inflight_reg;
      logic [CW-1:0]         issued_reg;
      logic [2:0]            credit;

      // Words held plus the word in flight, minus the one leaving this cycle;
      // a read is allowed only if it still fits in the 2-entry buffer.
      assign credit = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};

      assign lane_rd_en[gi] = run & ~lane_empty[gi] & ~lane_block[gi] &
                              (issued_reg < PC_C) & (credit < 3'd2);

      assign lane_head[gi]        = mem_reg[rd_ptr_reg];
      assign lane_head_valid[gi]  = (occ_reg != 2'd0);
      assign lane_issued_full[gi] = (issued_reg == PC_C);

      // Issue counter, in-flight flag and skid buffer for this lane.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[0]   <= '0;
          mem_reg[1]   <= '0;
          wr_ptr_reg   <= 1'b0;
          rd_ptr_reg   <= 1'b0;
          occ_reg      <= 2'd0;
          inflight_reg <= 1'b0;
          issued_reg   <= '0;
        end else begin
          if (frame_clear) begin
            issued_reg <= '0;
          end else if (lane_rd_en[gi] && (issued_reg < PC_C)) begin
            issued_reg <= issued_reg + CW'(1);
          end
          inflight_reg <= lane_rd_en[gi];
          if (inflight_reg) begin
            mem_reg[wr_ptr_reg] <= lane_rd_data[gi];
            wr_ptr_reg          <= ~wr_ptr_reg;
          end
          if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
          end
          occ_reg <= occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
        end
      end
    end
  endgenerate

`ifdef FIFO_DRAIN_OUT_REG_EN
  logic [2*DATA_WIDTH-1:0] out_data_reg;
  logic                    out_valid_reg;

  // The output register reloads whenever it is empty or being drained.
  assign pop = (&lane_head_valid) & (~out_valid_reg | out_ready);

  // Registered output stage: capture the head pair on each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (pop) begin
      out_data_reg  <= {lane_head[1], lane_head[0]};
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
`else
  assign out_valid = &lane_head_valid;
  assign out_data  = {lane_head[1], lane_head[0]};
  assign pop       = out_valid & out_ready;
`endif

  // State register and downstream pair counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      popped_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (frame_clear) begin
        popped_reg <= '0;
      end else if (accept && (popped_reg < PC_C)) begin
        popped_reg <= popped_reg + CW'(1);
      end
    end
  end

  // Next-state logic; the final handshake wins over the RUN->DRAIN move.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN: begin
        if (last_accept) begin
          state_next = S_DONE;
        end else if (&lane_issued_full) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: if (last_accept) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state_reg == S_RUN) | (state_reg == S_DRAIN);
  assign done = (state_reg == S_DONE);

endmodule
